// File: rtl/ir_tx.sv
// ---------------------------------------------------------------------------
// ir_tx : NEC-style infrared remote transmitter
//
// Serializes an 8-bit address and an 8-bit command into an NEC frame:
//   leader mark 16u, leader space 8u, 32 data bits (mark 1u + space 1u/3u),
//   stop mark 1u, gap 40u. The data word {~cmd, cmd, ~addr, addr} goes out
//   LSB first.
//
// Optional feature macro: IR_TX_REPEAT_EN
//   When defined, `hold` is sampled on the last gap cycle of each frame. If
//   it is high, a repeat frame follows: mark 16u, space 4u, stop mark 1u,
//   gap 150u. When undefined, `hold` is ignored and every frame ends in IDLE.
//
// Parameters:
//   UNIT_CYCLES : clock cycles per protocol unit (562.5 us)
//   CARRIER_DIV : clock cycles per carrier period (even, >= 2)
//
// Ports:
//   clk      in  system clock
//   rst      in  synchronous active-high reset
//   start    in  frame request, accepted only while busy = 0
//   addr     in  address byte, latched on acceptance
//   cmd      in  command byte, latched on acceptance
//   hold     in  key held, requests repeat frames (IR_TX_REPEAT_EN only)
//   busy     out high from the cycle after acceptance to the end of the gap
//   done     out one-cycle pulse on the last gap cycle of every frame
//   envelope out unmodulated mark (1) / space (0)
//   ir_out   out envelope AND carrier, drives the LED
// ---------------------------------------------------------------------------
module ir_tx #(
   parameter int unsigned UNIT_CYCLES = 28125,
   parameter int unsigned CARRIER_DIV = 1316
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] addr,
   input  logic [7:0] cmd,
   input  logic       hold,
   output logic       busy,
   output logic       done,
   output logic       envelope,
   output logic       ir_out
);

   localparam int unsigned UW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
   localparam int unsigned CW = $clog2(CARRIER_DIV);

   localparam logic [UW-1:0] UNIT_LAST = UW'(UNIT_CYCLES - 1);
   localparam logic [CW-1:0] CAR_LAST  = CW'(CARRIER_DIV - 1);
   localparam logic [CW-1:0] CAR_HALF  = CW'(CARRIER_DIV / 2);

   localparam logic [3:0] S_IDLE       = 4'd0;
   localparam logic [3:0] S_LEAD_MARK  = 4'd1;
   localparam logic [3:0] S_LEAD_SPACE = 4'd2;
   localparam logic [3:0] S_BIT_MARK   = 4'd3;
   localparam logic [3:0] S_BIT_SPACE  = 4'd4;
   localparam logic [3:0] S_STOP_MARK  = 4'd5;
   localparam logic [3:0] S_GAP        = 4'd6;
   localparam logic [3:0] S_REP_MARK   = 4'd7;
   localparam logic [3:0] S_REP_SPACE  = 4'd8;
   localparam logic [3:0] S_REP_GAP    = 4'd9;

   logic [3:0]    r_state;
   logic [UW-1:0] r_unit;     // cycle within the current unit
   logic [7:0]    r_units;    // units elapsed in the current state
   logic [CW-1:0] r_car;      // carrier phase
   logic [31:0]   r_shift;    // data word, bit 0 is the next bit to send
   logic [4:0]    r_bit;      // index of the bit being sent

`ifdef IR_TX_REPEAT_EN
   logic          r_rep;      // current frame is a repeat frame
`else
   logic          w_unused_hold;
   assign w_unused_hold = hold;
`endif

   logic [3:0]    w_next;
   logic [7:0]    w_len_m1;
   logic          w_unit_end;
   logic          w_state_end;
   logic          w_accept;
   logic          w_enter_mark;
   logic          w_next_is_mark;
   logic          w_is_mark;
   logic          w_is_gap;

   // State length in units, minus one
   always_comb begin
      w_len_m1 = 8'd0;
      case (r_state)
         S_LEAD_MARK:  w_len_m1 = 8'd15;
         S_LEAD_SPACE: w_len_m1 = 8'd7;
         S_BIT_MARK:   w_len_m1 = 8'd0;
         S_BIT_SPACE:  w_len_m1 = r_shift[0] ? 8'd2 : 8'd0;
         S_STOP_MARK:  w_len_m1 = 8'd0;
         S_GAP:        w_len_m1 = 8'd39;
         S_REP_MARK:   w_len_m1 = 8'd15;
         S_REP_SPACE:  w_len_m1 = 8'd3;
         S_REP_GAP:    w_len_m1 = 8'd149;
         default:      w_len_m1 = 8'd0;
      endcase
   end

   assign w_unit_end  = (r_unit == UNIT_LAST);
   assign w_state_end = (r_state != S_IDLE) && w_unit_end && (r_units == w_len_m1);
   assign w_accept    = (r_state == S_IDLE) && start;
   assign w_is_gap    = (r_state == S_GAP) || (r_state == S_REP_GAP);

   // Next-state logic; every state ends by moving to a different state
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:       if (start) w_next = S_LEAD_MARK;
         S_LEAD_MARK:  if (w_state_end) w_next = S_LEAD_SPACE;
         S_LEAD_SPACE: if (w_state_end) w_next = S_BIT_MARK;
         S_BIT_MARK:   if (w_state_end) w_next = S_BIT_SPACE;
         S_BIT_SPACE:  if (w_state_end) w_next = (r_bit == 5'd31) ? S_STOP_MARK : S_BIT_MARK;
`ifdef IR_TX_REPEAT_EN
         S_STOP_MARK:  if (w_state_end) w_next = r_rep ? S_REP_GAP : S_GAP;
         S_GAP:        if (w_state_end) w_next = hold ? S_REP_MARK : S_IDLE;
         S_REP_MARK:   if (w_state_end) w_next = S_REP_SPACE;
         S_REP_SPACE:  if (w_state_end) w_next = S_STOP_MARK;
         S_REP_GAP:    if (w_state_end) w_next = hold ? S_REP_MARK : S_IDLE;
`else
         S_STOP_MARK:  if (w_state_end) w_next = S_GAP;
         S_GAP:        if (w_state_end) w_next = S_IDLE;
`endif
         default:      w_next = S_IDLE;
      endcase
   end

   assign w_is_mark      = (r_state == S_LEAD_MARK) || (r_state == S_BIT_MARK) ||
                           (r_state == S_STOP_MARK) || (r_state == S_REP_MARK);
   assign w_next_is_mark = (w_next == S_LEAD_MARK) || (w_next == S_BIT_MARK) ||
                           (w_next == S_STOP_MARK) || (w_next == S_REP_MARK);
   // Marks are never entered from another mark, so a state change into a
   // mark marks its first cycle
   assign w_enter_mark   = w_next_is_mark && (w_next != r_state);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_unit  <= '0;
         r_units <= '0;
         r_car   <= '0;
         r_shift <= '0;
         r_bit   <= '0;
`ifdef IR_TX_REPEAT_EN
         r_rep   <= 1'b0;
`endif
      end else begin
         r_state <= w_next;

         if (w_next != r_state) begin
            r_unit  <= '0;
            r_units <= '0;
         end else if (r_state != S_IDLE) begin
            if (w_unit_end) begin
               r_unit  <= '0;
               r_units <= r_units + 8'd1;
            end else begin
               r_unit  <= r_unit + 1'b1;
            end
         end

         // Restarting the carrier on each mark makes every mark open high
         if (w_enter_mark || (r_car == CAR_LAST)) begin
            r_car <= '0;
         end else begin
            r_car <= r_car + 1'b1;
         end

         if (w_accept) begin
            r_shift <= {~cmd, cmd, ~addr, addr};
            r_bit   <= '0;
         end else if ((r_state == S_BIT_SPACE) && w_state_end) begin
            r_shift <= {1'b0, r_shift[31:1]};
            r_bit   <= r_bit + 5'd1;
         end

`ifdef IR_TX_REPEAT_EN
         if (w_accept) begin
            r_rep <= 1'b0;
         end else if (w_is_gap && w_state_end) begin
            r_rep <= hold;
         end
`endif
      end
   end

   assign busy     = (r_state != S_IDLE);
   assign envelope = w_is_mark;
   assign ir_out   = w_is_mark && (r_car < CAR_HALF);
   assign done     = w_is_gap && w_state_end;

endmodule

// File: tb/tb_ir_tx.sv
// ---------------------------------------------------------------------------
// tb_ir_tx : scoreboard bench for ir_tx (UNIT_CYCLES = 4, CARRIER_DIV = 2)
//
// Stimulus pushes the expected frame description into a queue; the monitor
// measures envelope run lengths, carrier and busy while a frame is on air,
// and on every done pulse pops one entry and compares.
// ---------------------------------------------------------------------------
module tb_ir_tx;

   localparam int unsigned U   = 4;
   localparam int unsigned DIV = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [7:0] addr = '0;
   logic [7:0] cmd = '0;
   logic       hold = 1'b0;
   logic       busy, done, envelope, ir_out;

   ir_tx #(.UNIT_CYCLES(U), .CARRIER_DIV(DIV)) dut (
      .clk(clk), .rst(rst), .start(start), .addr(addr), .cmd(cmd),
      .hold(hold), .busy(busy), .done(done), .envelope(envelope),
      .ir_out(ir_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          rep;
      logic [31:0] word;
      int          total;
      bit          busy_after;
   } item_t;

   item_t sb[$];
   int    checks = 0;
   int    errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push_full(input logic [31:0] w, input bit ba);
      item_t it;
      it.rep = 1'b0; it.word = w; it.total = 644; it.busy_after = ba;
      sb.push_back(it);
   endtask

   task automatic push_rep(input bit ba);
      item_t it;
      it.rep = 1'b1; it.word = '0; it.total = 684; it.busy_after = ba;
      sb.push_back(it);
   endtask

   // ---------------- monitor ----------------
   initial begin : monitor
      int    runs[$];
      bit    in_frame;
      bit    cur_lvl;
      int    cur_len;
      int    errs;
      bit    busy_pend;
      bit    busy_exp;
      item_t it;
      int    total;
      bit    shape_ok;
      logic [31:0] word;
      in_frame  = 0;
      busy_pend = 0;
      cur_lvl   = 0;
      cur_len   = 0;
      errs      = 0;
      busy_exp  = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            in_frame  = 0;
            busy_pend = 0;
            runs.delete();
         end else begin
            if (busy_pend) begin
               chk("busy_after_done", busy, busy_exp);
               busy_pend = 0;
            end
            if (!in_frame && envelope) begin
               in_frame = 1;
               runs.delete();
               cur_lvl = 1;
               cur_len = 0;
               errs    = 0;
            end
            if (in_frame) begin
               if (envelope !== cur_lvl) begin
                  runs.push_back(cur_len);
                  cur_lvl = envelope;
                  cur_len = 0;
               end
               if (ir_out !== (envelope && ((cur_len % DIV) < DIV / 2))) errs++;
               if (busy !== 1'b1) errs++;
               cur_len++;
               if (done) begin
                  runs.push_back(cur_len);
                  in_frame = 0;
                  total = 0;
                  foreach (runs[i]) total += runs[i];
                  if (sb.size() == 0) begin
                     chk("unexpected_done", 1, 0);
                  end else begin
                     it = sb.pop_front();
                     shape_ok = 1;
                     word = '0;
                     if (it.rep) begin
                        if (runs.size() != 4) shape_ok = 0;
                        else if (runs[0] != 64 || runs[1] != 16 || runs[2] != 4 || runs[3] != 600) shape_ok = 0;
                     end else begin
                        if (runs.size() != 68) shape_ok = 0;
                        else begin
                           if (runs[0] != 64 || runs[1] != 32 || runs[66] != 4 || runs[67] != 160) shape_ok = 0;
                           for (int b = 0; b < 32; b++) begin
                              if (runs[2 + 2 * b] != 4) shape_ok = 0;
                              if (runs[3 + 2 * b] == 12) word[b] = 1'b1;
                              else if (runs[3 + 2 * b] != 4) shape_ok = 0;
                           end
                        end
                        chk("frame_word", word, it.word);
                     end
                     chk(it.rep ? "repeat_shape" : "frame_shape", 32'(shape_ok), 1);
                     chk("frame_total", 32'(total), 32'(it.total));
                     chk("carrier_busy_violations", 32'(errs), 0);
                     busy_exp  = it.busy_after;
                     busy_pend = 1;
                  end
               end
            end else if (done) begin
               chk("done_outside_frame", 1, 0);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic send(input logic [7:0] a, input logic [7:0] c, input bit check_accept);
      @(posedge clk); #1;
      start = 1'b1; addr = a; cmd = c;
      @(posedge clk); #1;
      start = 1'b0; addr = ~a; cmd = ~c;
      if (check_accept) begin
         chk("accept_busy", busy, 1);
         chk("accept_envelope", envelope, 1);
         chk("accept_ir_out", ir_out, 1);
      end
   endtask

   task automatic wait_idle(input string name, input int bound);
      bit ok;
      ok = 0;
      for (int i = 0; i < bound; i++) begin
         @(negedge clk);
         if (sb.size() == 0 && !busy) begin
            ok = 1;
            break;
         end
      end
      chk(name, 32'(ok), 1);
   endtask

   task automatic check_quiet(input string name);
      chk({name, "_busy"}, busy, 0);
      chk({name, "_envelope"}, envelope, 0);
      chk({name, "_ir_out"}, ir_out, 0);
      chk({name, "_done"}, done, 0);
   endtask

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check_quiet("reset");

      // zero address and command
      push_full(32'hFF00_FF00, 1'b0);
      send(8'h00, 8'h00, 1'b1);
      wait_idle("idle_after_frame_00", 1000);

      // mixed pattern
      push_full(32'hC33C_5AA5, 1'b0);
      send(8'hA5, 8'h3C, 1'b1);
      wait_idle("idle_after_frame_a5", 1000);

      // start while busy is ignored
      push_full(32'h7E81_A15E, 1'b0);
      send(8'h5E, 8'h81, 1'b0);
      repeat (98) @(posedge clk);
      send(8'h11, 8'h22, 1'b0);
      wait_idle("idle_after_ignored_start", 1000);
      repeat (50) @(negedge clk);
      chk("no_second_frame", busy, 0);

      // reset mid-frame, then a clean frame
      send(8'h77, 8'h88, 1'b0);
      repeat (298) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      check_quiet("abort");
      @(posedge clk);
      push_full(32'hCB34_ED12, 1'b0);
      send(8'h12, 8'h34, 1'b1);
      wait_idle("idle_after_abort_frame", 1000);

      // start held high: two frames separated only by the gap
      push_full(32'hF00F_0FF0, 1'b0);
      push_full(32'h7F80_FE01, 1'b0);
      @(posedge clk); #1;
      start = 1'b1; addr = 8'hF0; cmd = 8'h0F;
      @(posedge clk); #1;
      addr = 8'h01; cmd = 8'h80;
      repeat (700) @(posedge clk);
      #1 start = 1'b0;
      wait_idle("idle_after_back_to_back", 1500);

      // hold high through the first repeat frame
`ifdef IR_TX_REPEAT_EN
      push_full(32'h00FF_FF00, 1'b1);
      push_rep(1'b1);
      push_rep(1'b0);
`else
      push_full(32'h00FF_FF00, 1'b0);
`endif
      @(posedge clk); #1 hold = 1'b1;
      send(8'h00, 8'hFF, 1'b1);
      repeat (644 + 684 + 300) @(posedge clk);
      #1 hold = 1'b0;
      wait_idle("idle_after_hold", 3000);

      repeat (200) @(negedge clk);
      chk("scoreboard_empty", 32'(sb.size()), 0);
      chk("final_busy", busy, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
